// File: rtl/ms_link_pkg.sv
// Shared defaults and width helpers for the master-to-slave FIFO link.
package ms_link_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 4;

  // Index width for an n-entry array; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ms_fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
// The array is deliberately left without reset; validity is tracked by the
// controller's level counter.
module ms_fifo_mem
  import ms_link_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = idx_w(DEF_DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Store the accepted word at the write pointer.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/ms_fifo_link.sv
// Buffered master-to-slave link: data_en-qualified writes into a DEPTH-entry
// FIFO, drained through a valid/ready port with a registered head word.
// Reports occupancy and a sticky overflow flag.
module ms_fifo_link
  import ms_link_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_en,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [LVL_W-1:0]  level,
  output logic              overflow,
  input  logic              clr_ovf
);

  localparam int PTR_W = idx_w(DEPTH);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              ovf_q, ovf_d;
  logic              full;
  logic              wr_en;
  logic              pop;
  logic [DATA_W-1:0] mem_rdata;

  // Readiness comes from the registered level only, so a pop never opens
  // a slot for a write in the same cycle.
  assign full     = (level_q == LVL_W'(DEPTH));
  assign in_ready = !full;

  ms_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (data_in),
    .rd_addr (rd_ptr_d),
    .rd_data (mem_rdata)
  );

  // Next-state for pointers, level, head register and overflow flag.
  always_comb begin
    wr_en       = data_en && !full;
    pop         = out_valid_q && out_ready;
    wr_ptr_d    = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d     = level_q;
    out_data_d  = out_data_q;
    ovf_d       = ovf_q;

    case ({wr_en, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    out_valid_d = (level_d != '0);

    // The head takes the incoming word when it becomes the oldest entry,
    // otherwise the next stored word after a pop; it holds when empty.
    if (wr_en && ((level_q == '0) || (pop && (level_q == LVL_W'(1))))) begin
      out_data_d = data_in;
    end else if (pop && (level_q > LVL_W'(1))) begin
      out_data_d = mem_rdata;
    end

    // Setting wins over clearing in the same cycle.
    if (data_en && full) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign level     = level_q;
  assign overflow  = ovf_q;

endmodule
